// File: rtl/lsu_pkg.sv
// Shared types, RV32I funct3 encodings and request decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // High when the request can never reach memory (misaligned or illegal encoding).
    function automatic logic req_bad(input logic [2:0] f3, input logic we, input logic [1:0] a);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = a[0];
            F3_W:    bad = (a != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] mem_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] mem_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane select and sign/zero extension of a 32-bit memory read word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    ld_value = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_value = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_value = {24'd0, shifted[7:0]};
            F3_HU:   ld_value = {16'd0, shifted[15:0]};
            default: ld_value = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between the core and a req/ack memory port.
// Optional access timeout enabled by defining LSU_TIMEOUT_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_e  state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] ld_value;

`ifdef LSU_TIMEOUT_EN
    logic [31:0] tmo_cnt;
`endif

    lsu_load_align u_load_align (
        .rdata    (i_mem_rdata),
        .addr_lo  (addr_lo_q),
        .funct3   (funct3_q),
        .ld_value (ld_value)
    );

    // State machine with all outputs registered; o_busy mirrors state != IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            addr_lo_q   <= 2'b00;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            o_ld_data   <= 32'd0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt     <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_lsu_valid) begin
                        addr_lo_q <= i_addr[1:0];
                        funct3_q  <= i_funct3;
                        we_q      <= i_lsu_wren;
                        o_busy    <= 1'b1;
                        if (req_bad(i_funct3, i_lsu_wren, i_addr[1:0])) begin
                            state  <= RESP;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_lsu_wren;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= mem_be(i_funct3, i_addr[1:0]);
                            o_mem_wdata <= mem_wdata(i_funct3, i_st_data);
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt     <= 32'd0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (i_mem_ack) begin
                        state     <= RESP;
                        o_mem_req <= 1'b0;
                        o_done    <= 1'b1;
                        o_err     <= 1'b0;
                        if (!we_q) begin
                            o_ld_data <= ld_value;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state     <= RESP;
                        o_mem_req <= 1'b0;
                        o_done    <= 1'b1;
                        o_err     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
`endif
                end
                RESP: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_err  <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_err  <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; timeout scenario runs only with LSU_TIMEOUT_EN.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_lsu_valid;
    logic        i_lsu_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic [31:0] o_ld_data;
    logic        o_done;
    logic        o_busy;
    logic        o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_lsu_valid (i_lsu_valid),
        .i_lsu_wren  (i_lsu_wren),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_st_data   (i_st_data),
        .o_ld_data   (o_ld_data),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        i_lsu_valid = 1'b1;
        i_lsu_wren  = we;
        i_funct3    = f3;
        i_addr      = a;
        i_st_data   = d;
        step();
        i_lsu_valid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_lsu_valid = 1'b0; i_lsu_wren = 1'b0; i_funct3 = 3'b000;
        i_addr = 32'd0; i_st_data = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
        step(); step();
        i_rst = 1'b0;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_req", o_mem_req, 0);
        check_eq("rst_ld", o_ld_data, 0);
        check_eq("rst_be", o_mem_be, 0);

        // LB 0x103, ack in first ACCESS cycle
        issue(1'b0, 3'b000, 32'h0000_0103, 32'd0);
        check_eq("lb_req", o_mem_req, 1);
        check_eq("lb_addr", o_mem_addr, 32'h0000_0100);
        check_eq("lb_be", o_mem_be, 4'b1000);
        check_eq("lb_we", o_mem_we, 0);
        check_eq("lb_busy", o_busy, 1);
        check_eq("lb_done_early", o_done, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h80FF_0000;
        step();
        i_mem_ack = 1'b0;
        check_eq("lb_done", o_done, 1);
        check_eq("lb_err", o_err, 0);
        check_eq("lb_data", o_ld_data, 32'hFFFF_FF80);
        check_eq("lb_req_drop", o_mem_req, 0);
        step();
        check_eq("lb_done_pulse", o_done, 0);
        check_eq("lb_idle", o_busy, 0);

        // SH 0x202, ack in third ACCESS cycle
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
        check_eq("sh_addr", o_mem_addr, 32'h0000_0200);
        check_eq("sh_be", o_mem_be, 4'b1100);
        check_eq("sh_wdata", o_mem_wdata, 32'hABCD_ABCD);
        check_eq("sh_we", o_mem_we, 1);
        step();
        check_eq("sh_hold_req", o_mem_req, 1);
        check_eq("sh_hold_addr", o_mem_addr, 32'h0000_0200);
        step();
        check_eq("sh_hold_be", o_mem_be, 4'b1100);
        check_eq("sh_no_done", o_done, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        step();
        i_mem_ack = 1'b0;
        check_eq("sh_done", o_done, 1);
        check_eq("sh_ld_keep", o_ld_data, 32'hFFFF_FF80);
        step();
        check_eq("sh_done_once", o_done, 0);

        // ack while idle must be ignored
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        check_eq("idle_ack_busy", o_busy, 0);
        check_eq("idle_ack_done", o_done, 0);

        // LW 0x101 misaligned: immediate error, no memory request
        issue(1'b0, 3'b010, 32'h0000_0101, 32'd0);
        check_eq("lw_mis_req", o_mem_req, 0);
        check_eq("lw_mis_done", o_done, 1);
        check_eq("lw_mis_err", o_err, 1);
        check_eq("lw_mis_ld", o_ld_data, 32'hFFFF_FF80);
        step();
        check_eq("lw_mis_idle", o_busy, 0);
        check_eq("lw_mis_req2", o_mem_req, 0);

        // SBU-style illegal store (funct3 100 with wren)
        issue(1'b1, 3'b100, 32'h0000_0010, 32'd0);
        check_eq("illegal_err", o_err, 1);
        check_eq("illegal_req", o_mem_req, 0);
        step();

        // LHU 0x002 with a second valid during ACCESS
        issue(1'b0, 3'b101, 32'h0000_0002, 32'd0);
        check_eq("lhu_be", o_mem_be, 4'b1100);
        i_lsu_valid = 1'b1; i_lsu_wren = 1'b1; i_funct3 = 3'b010;
        i_addr = 32'h0000_0300; i_st_data = 32'h5555_5555;
        step();
        i_lsu_valid = 1'b0;
        check_eq("lhu_ign_addr", o_mem_addr, 32'h0000_0000);
        check_eq("lhu_ign_we", o_mem_we, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hBEEF_0000;
        step();
        i_mem_ack = 1'b0;
        check_eq("lhu_done", o_done, 1);
        check_eq("lhu_data", o_ld_data, 32'h0000_BEEF);
        step();
        check_eq("lhu_idle", o_busy, 0);

        // SB replication and LH sign extension
        issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5);
        check_eq("sb_be", o_mem_be, 4'b0010);
        check_eq("sb_wdata", o_mem_wdata, 32'hA5A5_A5A5);
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        step();
        issue(1'b0, 3'b001, 32'h0000_0000, 32'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_8001;
        step();
        i_mem_ack = 1'b0;
        check_eq("lh_data", o_ld_data, 32'hFFFF_8001);
        step();

`ifdef LSU_TIMEOUT_EN
        // no ack: request held for exactly 4 ACCESS cycles, then error
        issue(1'b0, 3'b010, 32'h0000_0040, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("tmo_req%0d", i), o_mem_req, 1);
            step();
        end
        check_eq("tmo_req_drop", o_mem_req, 0);
        check_eq("tmo_done", o_done, 1);
        check_eq("tmo_err", o_err, 1);
        step();
`endif

        // reset in the middle of ACCESS
        issue(1'b0, 3'b010, 32'h0000_0400, 32'd0);
        check_eq("rstacc_req", o_mem_req, 1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_eq("rstacc_busy", o_busy, 0);
        check_eq("rstacc_req0", o_mem_req, 0);
        check_eq("rstacc_done", o_done, 0);
        check_eq("rstacc_ld", o_ld_data, 0);
        check_eq("rstacc_addr", o_mem_addr, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        step();
        i_mem_ack = 1'b0;
        check_eq("rstacc_late_ack", o_done, 0);
        check_eq("rstacc_late_ld", o_ld_data, 0);
        step();
        check_eq("rstacc_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of ACCESS-state cycles before abort (used only with LSU_TIMEOUT_EN).
REQ-002 The block SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port i_lsu_valid  in  1  access request from the core.
REQ-005 The block SHALL have port i_lsu_wren  in  1  1 = store, 0 = load.
REQ-006 The block SHALL have port i_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 The block SHALL have port i_addr  in  32  byte address (ALU result).
REQ-008 The block SHALL have port i_st_data  in  32  store data (rs2).
REQ-009 The block SHALL have port o_ld_data  out  32  formatted load result.
REQ-010 The block SHALL have ports o_done  out  1  one-cycle completion pulse; o_busy  out  1  stall to core; o_err  out  1  error flag, valid with o_done.
REQ-011 The block SHALL have memory-side ports: o_mem_req out 1; o_mem_we out 1; o_mem_addr out 32 (word-aligned); o_mem_be out 4; o_mem_wdata out 32; i_mem_ack in 1; i_mem_rdata in 32.

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS, RESP; o_busy = (state != IDLE).
REQ-013 In IDLE, i_lsu_valid=1 SHALL register i_addr, i_funct3, i_lsu_wren, and i_st_data, then move to ACCESS; if the request is misaligned or illegal, it SHALL move to RESP with error set instead.
REQ-014 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal: funct3 011/110/111, or 100/101 with a store.
REQ-015 i_lsu_valid SHALL be ignored outside IDLE.
REQ-016 In ACCESS, o_mem_req SHALL be 1 and held with stable addr/we/be/wdata until a cycle where i_mem_ack=1; that cycle SHALL transition to RESP. An ack in the first ACCESS cycle is legal.
REQ-017 o_mem_addr SHALL be {addr[31:2],2'b00}. o_mem_be SHALL be: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-018 o_mem_wdata SHALL be: SB {4{data[7:0]}}; SH {2{data[15:0]}}; SW data.
REQ-019 On a load ack, i_mem_rdata SHALL be lane-selected by addr[1:0], sign-extended (B/H) or zero-extended (BU/HU), and registered into o_ld_data.
REQ-020 o_ld_data SHALL hold its value until the next successful load; stores and errors SHALL NOT change it.
REQ-021 RESP SHALL last exactly one cycle with o_done=1, then return to IDLE. Minimum latency is valid at cycle N to o_done at cycle N+2.
REQ-022 i_mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-023 i_rst=1 SHALL force IDLE and zero o_ld_data, o_done, o_err, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, and the timeout counter, including mid-ACCESS. The pending access SHALL be abandoned without o_done.

Configuration
REQ-024 With LSU_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; at TIMEOUT_CYCLES it SHALL drop o_mem_req and go to RESP with o_err=1.
REQ-025 Without LSU_TIMEOUT_EN, there SHALL be no counter; ACCESS SHALL wait indefinitely for ack.

Structure
REQ-026 Package lsu_pkg SHALL hold the state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-027 Sub-module lsu_load_align SHALL be combinational: (rdata, addr[1:0], funct3) -> 32-bit extended load value.

Verification
REQ-028 LB at 0x103, rdata 0x80FF_0000, ack on first ACCESS cycle -> o_done at N+2, o_ld_data 0xFFFF_FF80, o_err 0.
REQ-029 SH at 0x202, st_data 0x1234_ABCD -> o_mem_addr 0x200, be 4'b1100, wdata 0xABCD_ABCD; ack after 3 cycles -> o_done once, o_ld_data unchanged.
REQ-030 LW at 0x101 -> no o_mem_req ever, o_done with o_err=1 at N+1.
REQ-031 LHU at 0x002, rdata 0xBEEF_0000 -> o_ld_data 0x0000_BEEF; a second valid during ACCESS is ignored.
REQ-032 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> o_mem_req deasserts after 4 ACCESS cycles, o_done with o_err=1.
REQ-033 i_rst asserted during ACCESS -> next cycle IDLE, o_mem_req 0, no o_done; a later ack is ignored.
